// File: rtl/lvds_pattern_gen.sv
// lvds_pattern_gen: video timing generator with a selectable test pattern.
// Four patterns are available: colour bars, gradient, checkerboard and solid.
// Every output is registered one pixel after the counter state it reflects.
// Optional feature: define LVDS_PATTERN_GEN_LED_EN to get the led heartbeat;
// without it, led is tied low.
module lvds_pattern_gen #(
  parameter int H_ACTIVE  = 1366,
  parameter int H_FP      = 1,
  parameter int H_SW      = 24,
  parameter int H_BP      = 25,
  parameter int V_ACTIVE  = 768,
  parameter int V_FP      = 1,
  parameter int V_SW      = 5,
  parameter int V_BP      = 6,
  parameter int BARS_LOG2 = 3,
  parameter int BAR_SHIFT = 7,
  parameter int CHK_SHIFT = 5,
  parameter int LED_DIV   = 36000000
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            pix_en,
  input  logic [1:0]                      mode,
  input  logic [16*(1<<BARS_LOG2)-1:0]    palette,
  output logic                            de,
  output logic                            hsync,
  output logic                            vsync,
  output logic [7:0]                      red,
  output logic [7:0]                      green,
  output logic [7:0]                      blue,
  output logic                            frame_start,
  output logic                            led
);

  localparam int BARS    = 1 << BARS_LOG2;
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SW + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SW + V_BP;
  // Counters are kept wide enough for the gradient (hcnt[7:0]) and the
  // checkerboard bit, even when the timing itself needs fewer bits.
  localparam int HW0 = $clog2(H_TOTAL);
  localparam int HW1 = (HW0 > 8) ? HW0 : 8;
  localparam int HW  = (HW1 > CHK_SHIFT + 1) ? HW1 : CHK_SHIFT + 1;
  localparam int VW0 = $clog2(V_TOTAL);
  localparam int VW  = (VW0 > CHK_SHIFT + 1) ? VW0 : CHK_SHIFT + 1;

  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_GRAD  = 2'd1,
    PAT_CHK   = 2'd2,
    PAT_SOLID = 2'd3
  } pat_t;

  logic [HW-1:0]        hcnt;
  logic [VW-1:0]        vcnt;
  pat_t                 mode_q;

  logic                 at_origin;
  pat_t                 pat;
  logic                 de_c, hs_c, vs_c;
  logic [HW-1:0]        bar_idx;
  logic [BARS_LOG2-1:0] bar_k;
  logic [15:0]          bar_px;
  logic [23:0]          rgb_c;

  // Palette word to 24-bit colour: B[15:11], R[10:6], G[5:1], 5->8 bit expand.
  function automatic logic [23:0] decode(input logic [15:0] p);
    logic [4:0] r5, g5, b5;
    b5 = p[15:11];
    r5 = p[10:6];
    g5 = p[5:1];
    return {r5, r5[4:2], g5, g5[4:2], b5, b5[4:2]};
  endfunction

  // Raster position counters; hold while pix_en is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (pix_en) begin
      if (hcnt == HW'(H_TOTAL - 1)) begin
        hcnt <= '0;
        vcnt <= (vcnt == VW'(V_TOTAL - 1)) ? '0 : vcnt + 1'b1;
      end else begin
        hcnt <= hcnt + 1'b1;
      end
    end
  end

  // Active pattern is only taken at the frame origin so frames never tear.
  always_ff @(posedge clk) begin
    if (rst)
      mode_q <= PAT_BARS;
    else if (pix_en && at_origin)
      mode_q <= pat_t'(mode);
  end

  // Timing flags and pixel colour for the current counter position.
  always_comb begin
    at_origin = (hcnt == '0) && (vcnt == '0);
    // The origin pixel already belongs to the new frame, so it uses the
    // incoming mode directly rather than the not-yet-updated register.
    pat     = at_origin ? pat_t'(mode) : mode_q;
    de_c    = (hcnt < HW'(H_ACTIVE)) && (vcnt < VW'(V_ACTIVE));
    hs_c    = !((hcnt >= HW'(H_ACTIVE + H_FP)) &&
                (hcnt <  HW'(H_ACTIVE + H_FP + H_SW)));
    vs_c    = !((vcnt >= VW'(V_ACTIVE + V_FP)) &&
                (vcnt <  VW'(V_ACTIVE + V_FP + V_SW)));
    bar_idx = hcnt >> BAR_SHIFT;
    bar_k   = (bar_idx > HW'(BARS - 1)) ? BARS_LOG2'(BARS - 1)
                                        : bar_idx[BARS_LOG2-1:0];
    bar_px  = palette[{bar_k, 4'b0000} +: 16];
    rgb_c   = '0;
    case (pat)
      PAT_BARS:  rgb_c = decode(bar_px);
      PAT_GRAD:  rgb_c = {3{hcnt[7:0]}};
      PAT_CHK:   rgb_c = (hcnt[CHK_SHIFT] ^ vcnt[CHK_SHIFT]) ? '1 : '0;
      PAT_SOLID: rgb_c = decode(palette[15:0]);
      default:   rgb_c = '0;
    endcase
    if (!de_c)
      rgb_c = '0;
  end

  // Output register: one pixel of latency, frozen while pix_en is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      de          <= 1'b0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      frame_start <= 1'b0;
    end else if (pix_en) begin
      de          <= de_c;
      hsync       <= hs_c;
      vsync       <= vs_c;
      {red, green, blue} <= rgb_c;
      frame_start <= at_origin;
    end
  end

`ifdef LVDS_PATTERN_GEN_LED_EN
  localparam int LW = (LED_DIV > 1) ? $clog2(LED_DIV) : 1;
  logic [LW-1:0] led_cnt;

  // Heartbeat: free-running divider, toggles led every LED_DIV clocks.
  always_ff @(posedge clk) begin
    if (rst) begin
      led_cnt <= '0;
      led     <= 1'b0;
    end else if (led_cnt == LW'(LED_DIV - 1)) begin
      led_cnt <= '0;
      led     <= ~led;
    end else begin
      led_cnt <= led_cnt + 1'b1;
    end
  end
`else
  assign led = 1'b0;
`endif

endmodule

// File: doc/lvds_pattern_gen.md
LVDS_PATTERN_GEN -- requirements
Module: lvds_pattern_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 1366, active pixels per line.
REQ-002 SHALL have parameter H_FP / H_SW / H_BP, defaults 1 / 24 / 25, horizontal front porch, sync width and back porch in pixels.
REQ-003 SHALL have parameter V_ACTIVE, default 768, active lines per frame.
REQ-004 SHALL have parameter V_FP / V_SW / V_BP, defaults 1 / 5 / 6, vertical porches and sync width in lines.
REQ-005 SHALL have parameter BARS_LOG2, default 3, log2 of the colour-bar count (BARS = 2^BARS_LOG2).
REQ-006 SHALL have parameter BAR_SHIFT, default 7, log2 of the bar width in pixels.
REQ-007 SHALL have parameter CHK_SHIFT, default 5, log2 of the checkerboard square size.
REQ-008 SHALL have parameter LED_DIV, default 36000000, heartbeat half-period in clocks.
REQ-009 SHALL have port clk, input, 1 bit, pixel clock; all logic is on its rising edge; one clock only.
REQ-010 SHALL have port rst, input, 1 bit, synchronous, active-high reset.
REQ-011 SHALL have port pix_en, input, 1 bit, pixel-advance enable.
REQ-012 SHALL have port mode, input, 2 bits, pattern select.
REQ-013 SHALL have port palette, input, 16*BARS bits, bar colour k at [16k+15:16k].
REQ-014 SHALL have port de / hsync / vsync, output, 1 bit each, data enable and active-low syncs.
REQ-015 SHALL have port red / green / blue, output, 8 bits each, pixel colour.
REQ-016 SHALL have port frame_start, output, 1 bit, one-pixel pulse at pixel (0,0).
REQ-017 SHALL have port led, output, 1 bit, heartbeat.

Function
REQ-018 SHALL define H_TOTAL = H_ACTIVE+H_FP+H_SW+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SW+V_BP.
REQ-019 SHALL run hcnt 0..H_TOTAL-1 and vcnt 0..V_TOTAL-1; counters hold when pix_en=0.
REQ-020 SHALL advance hcnt on pix_en; at hcnt=H_TOTAL-1 it wraps to 0 and vcnt increments, and vcnt wraps to 0 after V_TOTAL-1.
REQ-021 SHALL register every output exactly 1 cycle after the counter state it reflects (latency 1); outputs hold while pix_en=0.
REQ-022 SHALL assert de iff hcnt<H_ACTIVE and vcnt<V_ACTIVE.
REQ-023 SHALL drive hsync=0 iff H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SW; otherwise 1.
REQ-024 SHALL drive vsync=0 iff V_ACTIVE+V_FP <= vcnt < V_ACTIVE+V_FP+V_SW for the whole line; otherwise 1.
REQ-025 SHALL assert frame_start for the one output pixel where hcnt=0 and vcnt=0.
REQ-026 SHALL latch mode into an internal active mode only when the counters are at (0,0) and pix_en=1, so that mode changes never tear a frame.
REQ-027 SHALL produce pattern mode 0 (bars) as palette entry k = min(hcnt>>BAR_SHIFT, BARS-1).
REQ-028 SHALL decode the bar colour as B=p[15:11], R=p[10:6], G=p[5:1], each expanded to 8 bits as {x[4:0], x[4:2]}.
REQ-029 SHALL produce mode 1 as a gradient with red=green=blue=hcnt[7:0].
REQ-030 SHALL produce mode 2 as a checkerboard: all channels 8'hFF when hcnt[CHK_SHIFT]^vcnt[CHK_SHIFT] is 1, else 8'h00.
REQ-031 SHALL produce mode 3 as solid palette entry 0.
REQ-032 SHALL force red/green/blue to 0 whenever de is 0.
REQ-033 SHALL make the led counter independent of pix_en: it toggles led and clears when the counter reaches LED_DIV-1.

Reset
REQ-034 SHALL apply on rst=1 at a clk edge: hcnt=0, vcnt=0, active mode=0, led counter=0, led=0.
REQ-035 SHALL apply on rst=1 at a clk edge: de=0, hsync=1, vsync=1, RGB=0, frame_start=0.
REQ-036 SHALL give rst priority over pix_en; a reset mid-line or mid-frame restarts at (0,0).
REQ-037 SHALL present pixel (0,0) on the outputs, with frame_start=1, on the first pix_en cycle after reset release.

Configuration
REQ-038 SHALL include the led counter and REQ-033 when macro LVDS_PATTERN_GEN_LED_EN is defined.
REQ-039 SHALL drive led constant 0 with no counter logic when LVDS_PATTERN_GEN_LED_EN is undefined.

Verification
REQ-040 SHALL cover, with H_ACTIVE=8, H_FP=1, H_SW=2, H_BP=1, V_ACTIVE=4, V_FP=V_SW=V_BP=1 and pix_en=1: de high 8 of every 12 pixels on lines 0-3, hsync low at hcnt 9-10, vsync low on line 5, frame_start every 84 cycles.
REQ-041 SHALL cover mode 0, BAR_SHIFT=1, BARS_LOG2=2, palette entry 1=16'hFFFF: pixels 2-3 show FF/FF/FF, and pixels 6-7 use entry 3.
REQ-042 SHALL cover mode switching from 0 to 2 mid-frame: the pattern stays bars until the next frame_start, then becomes checkerboard.
REQ-043 SHALL cover pix_en toggled 1,0,0,1: outputs and counters freeze for 2 cycles, then resume with no skipped pixel.
REQ-044 SHALL cover rst asserted at hcnt=5, vcnt=2: next-cycle outputs equal the REQ-035 values, and after release frame_start=1 on the first pixel.
REQ-045 SHALL cover LVDS_PATTERN_GEN_LED_EN with LED_DIV=4: led toggles every 4 cycles; with the macro undefined, led stays 0.
